// File: rtl/pci_pkg.sv
// Shared arbiter definitions: FSM state encoding and default sizing.
package pci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_e;

    localparam int N_MASTERS_DEF   = 4;
    localparam int GNT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pci_arbiter_if.sv
// Arbiter bus bundle: requests and bus phase signals in, grants and status out.
interface pci_arbiter_if #(
    parameter int N_MASTERS = pci_pkg::N_MASTERS_DEF
);
    localparam int OW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req_n;
    logic                 frame_n;
    logic                 irdy_n;
    logic [N_MASTERS-1:0] gnt_n;
    logic [OW-1:0]        owner;
    logic                 bus_busy;
    logic                 timeout_pulse;

    // Requester / bus-monitor side
    modport master (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, timeout_pulse
    );

    // Arbiter side
    modport slave (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, timeout_pulse
    );
endinterface

// File: rtl/pci_rr_sel.sv
// Round-robin winner select: scans upward from the slot after last_i, wrapping.
module pci_rr_sel #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] win_o,
    output logic         vld_o
);
    int          idx;
    logic [W-1:0] idx_w;

    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        idx_w = '0;
        // last_i itself is checked last so the master just served has lowest priority
        for (int i = 1; i <= N; i++) begin
            idx = int'(last_i) + i;
            if (idx >= N) idx = idx - N;
            idx_w = W'(idx);
            if (!vld_o && req_i[idx_w]) begin
                vld_o = 1'b1;
                win_o = idx_w;
            end
        end
    end
endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grant, FRAME timeout, mandatory turnaround cycle.
// Optional macro PCI_ARB_PARK_EN parks the bus on master 0 when nobody requests.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = N_MASTERS_DEF,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pci_arbiter_if.slave  bus
);
    localparam int OW = $clog2(N_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 bus_idle;
    logic [OW-1:0]        win;
    logic                 win_vld;

    assign bus_idle = bus.frame_n & bus.irdy_n;

    pci_rr_sel #(.N(N_MASTERS), .W(OW)) u_rr_sel (
        .req_i  (~bus.req_n),
        .last_i (last_q),
        .win_o  (win),
        .vld_o  (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_n_q <= '1;
            owner_q <= '0;
            last_q  <= OW'(N_MASTERS - 1);
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_n_q <= gnt_n_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PCI_ARB_PARK_EN
    logic parked;
    assign parked = ~gnt_n_q[0];
`endif

    always_comb begin
        state_d = state_q;
        gnt_n_d = gnt_n_q;
        owner_d = owner_q;
        last_d  = last_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (parked && !bus.frame_n) begin
                    // Parked master 0 started a cycle without arbitrating
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    gnt_n_d = '1;
                    last_d  = '0;
                    owner_d = '0;
                end else if (win_vld && bus_idle) begin
                    if (parked && win != '0) begin
                        state_d = ST_TURN;
                        gnt_n_d = '1;
                    end else begin
                        state_d = ST_GRANT;
                        gnt_n_d = ~(N_MASTERS'(1) << win);
                        owner_d = win;
                        last_d  = win;
                        cnt_d   = '0;
                    end
                end else if (!win_vld) begin
                    gnt_n_d = ~N_MASTERS'(1);
                    owner_d = '0;
                end
`else
                if (win_vld && bus_idle) begin
                    state_d = ST_GRANT;
                    gnt_n_d = ~(N_MASTERS'(1) << win);
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                end
`endif
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CW'(1);
                if (!bus.frame_n) begin
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    gnt_n_d = '1;
                end else if (bus.req_n[owner_q]) begin
                    state_d = ST_TURN;
                    gnt_n_d = '1;
                end else if (cnt_q == CW'(GNT_TIMEOUT - 1)) begin
                    // last_q already holds the owner, so rotation skips it next time
                    state_d = ST_TURN;
                    gnt_n_d = '1;
                    tmo_d   = 1'b1;
                end
            end
            ST_BUSY: begin
                gnt_n_d = '1;
                if (bus_idle) begin
                    state_d = ST_TURN;
                    busy_d  = 1'b0;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                gnt_n_d = '1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt_n         = gnt_n_q;
    assign bus.owner         = owner_q;
    assign bus.bus_busy      = busy_q;
    assign bus.timeout_pulse = tmo_q;

endmodule
